// File: rtl/mux4way_rr.sv
// -----------------------------------------------------------------------------
// mux4way_rr
//   Four-channel round-robin multiplexer with a single registered output slot.
//   Each cycle the slot is free, the first valid channel at or after the
//   rotating pointer is accepted and its word is loaded into the output
//   register one cycle later. A slot that drains can be refilled on the same
//   edge, so the block sustains one word per cycle.
//
//   Optional feature: define MUX4WAY_RR_COUNT_EN to add the 16-bit xfer_count
//   output. It counts completed output transfers and wraps from 0xFFFF to 0.
// -----------------------------------------------------------------------------
module mux4way_rr #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [3:0]         in_valid,
  input  logic [4*WIDTH-1:0] in_data,
  output logic [3:0]         in_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [1:0]         out_sel,
`ifdef MUX4WAY_RR_COUNT_EN
  output logic [15:0]        xfer_count,
`endif
  input  logic               out_ready
);

  // Output slot and arbitration state
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic [1:0]       r_out_sel;
  logic [1:0]       r_ptr;

  // Arbitration results
  logic             w_slot_free;
  logic             w_drain;
  logic             w_any_valid;
  logic [1:0]       w_grant_idx;
  logic             w_grant;
  logic [WIDTH-1:0] w_grant_data;

  // The slot can take a new word if it is empty or is emptying this cycle.
  assign w_drain     = r_out_valid & out_ready;
  assign w_slot_free = ~r_out_valid | out_ready;

  // Search the channels starting at the pointer and wrapping modulo 4.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path through the block leaves it unassigned, which would infer a latch.
    w_any_valid = 1'b0;
    w_grant_idx = 2'd0;
    for (int k = 0; k < 4; k++) begin
      logic [1:0] idx;
      idx = r_ptr + k[1:0];
      if (!w_any_valid && in_valid[idx]) begin
        w_any_valid = 1'b1;
        w_grant_idx = idx;
      end
    end
  end

  // A grant needs a free slot; reset blocks all accepts so none are lost.
  assign w_grant      = w_any_valid & w_slot_free & ~reset;
  assign w_grant_data = in_data[w_grant_idx*WIDTH +: WIDTH];

  // One-hot accept strobe toward the granted channel.
  always_comb begin
    in_ready = 4'b0000;
    if (w_grant) begin
      in_ready[w_grant_idx] = 1'b1;
    end
  end

  // Output slot and pointer: load on grant, clear on drain without refill.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values and simulation matches the synthesized flops.
    // The data register is reset too, since its reset value is observable.
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sel   <= 2'd0;
      r_ptr       <= 2'd0;
    end else if (w_grant) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_grant_data;
      r_out_sel   <= w_grant_idx;
      r_ptr       <= w_grant_idx + 2'd1;
    end else if (w_drain) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_sel   = r_out_sel;

`ifdef MUX4WAY_RR_COUNT_EN
  logic [15:0] r_xfer_count;

  // Count completed output transfers; wraps naturally at 16 bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_xfer_count <= 16'd0;
    end else if (w_drain) begin
      r_xfer_count <= r_xfer_count + 16'd1;
    end
  end

  assign xfer_count = r_xfer_count;
`endif

endmodule

// File: tb/tb_mux4way_rr.sv
// -----------------------------------------------------------------------------
// tb_mux4way_rr
//   Directed self-checking bench for mux4way_rr (WIDTH=16). Inputs change #1
//   after the rising edge; combinational and registered outputs are sampled
//   after that settle time, away from the edge.
//   With MUX4WAY_RR_COUNT_EN defined, the transfer counter is also exercised.
// -----------------------------------------------------------------------------
module tb_mux4way_rr;

  localparam int WIDTH = 16;

  logic               clk;
  logic               reset;
  logic [3:0]         in_valid;
  logic [4*WIDTH-1:0] in_data;
  logic [3:0]         in_ready;
  logic               out_valid;
  logic [WIDTH-1:0]   out_data;
  logic [1:0]         out_sel;
  logic               out_ready;
`ifdef MUX4WAY_RR_COUNT_EN
  logic [15:0]        xfer_count;
`endif

  int checks = 0;
  int errors = 0;

  mux4way_rr #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
`ifdef MUX4WAY_RR_COUNT_EN
    .xfer_count(xfer_count),
`endif
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle 1 time unit past the edge.
  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input logic [15:0] d0, input logic [15:0] d1,
                          input logic [15:0] d2, input logic [15:0] d3);
    in_data = {d3, d2, d1, d0};
  endtask

  initial begin
    // ---- Reset state, with inputs active to show in_ready is gated ----
    reset     = 1'b1;
    in_valid  = 4'b1111;
    out_ready = 1'b0;
    set_data(16'h0A0A, 16'h0B0B, 16'h0C0C, 16'h0D0D);
    step; step;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data",  {16'd0, out_data},  32'd0);
    check("rst_out_sel",   {30'd0, out_sel},   32'd0);
    check("rst_in_ready",  {28'd0, in_ready},  32'd0);

    // ---- Single channel 2 valid ----
    reset     = 1'b0;
    in_valid  = 4'b0100;
    out_ready = 1'b1;
    set_data(16'hFFFF, 16'hEEEE, 16'h1234, 16'hDDDD);
    #1;
    check("ch2_in_ready", {28'd0, in_ready}, 32'h4);
    step;
    check("ch2_out_valid", {31'd0, out_valid}, 32'd1);
    check("ch2_out_data",  {16'd0, out_data},  32'h1234);
    check("ch2_out_sel",   {30'd0, out_sel},   32'd2);

    // ---- ptr=3, channels 1 and 3 valid: 3 then wrap to 1 ----
    in_valid = 4'b1010;
    set_data(16'h0000, 16'h1111, 16'h2222, 16'h3333);
    #1;
    check("wrap_in_ready_a", {28'd0, in_ready}, 32'h8);
    step;
    check("wrap_sel_a",  {30'd0, out_sel},  32'd3);
    check("wrap_data_a", {16'd0, out_data}, 32'h3333);
    check("wrap_in_ready_b", {28'd0, in_ready}, 32'h2);
    step;
    check("wrap_sel_b",  {30'd0, out_sel},  32'd1);
    check("wrap_data_b", {16'd0, out_data}, 32'h1111);

    // ---- Backpressure for 3 cycles with slot full (ptr=2) ----
    in_valid  = 4'b1111;
    out_ready = 1'b0;
    set_data(16'h000A, 16'h000B, 16'h000C, 16'h000D);
    for (int c = 0; c < 3; c++) begin
      #1;
      check("bp_in_ready", {28'd0, in_ready}, 32'h0);
      step;
      check("bp_out_valid", {31'd0, out_valid}, 32'd1);
      check("bp_out_data",  {16'd0, out_data},  32'h1111);
      check("bp_out_sel",   {30'd0, out_sel},   32'd1);
    end
    // Release: drain and reload on the same edge, next grant is channel 2.
    out_ready = 1'b1;
    #1;
    check("bp_release_in_ready", {28'd0, in_ready}, 32'h4);
    step;
    check("bp_reload_valid", {31'd0, out_valid}, 32'd1);
    check("bp_reload_sel",   {30'd0, out_sel},   32'd2);
    check("bp_reload_data",  {16'd0, out_data},  32'h000C);

    // ---- Reset asserted mid-cycle while out_valid=1 ----
    #2;
    reset = 1'b1;
    #1;
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_out_data",  {16'd0, out_data},  32'd0);
    check("midrst_out_sel",   {30'd0, out_sel},   32'd0);
    check("midrst_in_ready",  {28'd0, in_ready},  32'd0);
    step;
    reset = 1'b0;
    #1;
    check("postrst_in_ready", {28'd0, in_ready}, 32'h1);

    // ---- All valid, out_ready held: 0,1,2,3,0 with no bubble ----
    begin
      logic [1:0]  exp_sel [5];
      logic [15:0] exp_dat [5];
      exp_sel = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      exp_dat = '{16'h000A, 16'h000B, 16'h000C, 16'h000D, 16'h000A};
      for (int i = 0; i < 5; i++) begin
        step;
        check("rr_out_valid", {31'd0, out_valid}, 32'd1);
        check("rr_out_sel",   {30'd0, out_sel},   {30'd0, exp_sel[i]});
        check("rr_out_data",  {16'd0, out_data},  {16'd0, exp_dat[i]});
      end
    end

    // ---- Drain with nothing valid: out_valid clears, ptr held at 1 ----
    in_valid = 4'b0000;
    step;
    check("idle_out_valid", {31'd0, out_valid}, 32'd0);
    step;
    in_valid = 4'b1111;
    #1;
    check("idle_ptr_in_ready", {28'd0, in_ready}, 32'h2);

    // ---- Channel drops valid without a transfer; other channel data ignored ----
    in_valid = 4'b0000;
    set_data(16'h5555, 16'h6666, 16'h7777, 16'h8888);
    step;
    check("drop_out_valid", {31'd0, out_valid}, 32'd0);
    in_valid = 4'b0001;
    step;
    check("drop_sel",  {30'd0, out_sel},  32'd0);
    check("drop_data", {16'd0, out_data}, 32'h5555);

`ifdef MUX4WAY_RR_COUNT_EN
    // ---- Transfer counter wraps: 65537 transfers leave count at 1 ----
    reset    = 1'b1;
    in_valid = 4'b0001;
    step;
    check("cnt_reset", {16'd0, xfer_count}, 32'd0);
    reset     = 1'b0;
    out_ready = 1'b1;
    // First edge only loads; each further edge completes one transfer.
    for (int n = 0; n < 65538; n++) step;
    check("cnt_wrap", {16'd0, xfer_count}, 32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
